// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sequencing an external full adder
// Optional datapath self-check: define SERIAL_ADD_CHECK_EN to build the err logic.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic [1:0]       fa_y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             err
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             running;
  logic             accept;
  logic [WIDTH-1:0] res_shifted;

  assign running     = (state_q == ST_RUN);
  // Only IDLE and DONE listen to start; a request during RUN is dropped.
  assign accept      = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // Sum bits arrive LSB first, so they enter at the MSB and walk down.
  assign res_shifted = {fa_y[0], res_q[WIDTH-1:1]};

  // Full-adder inputs are gated so the datapath sees zeros outside RUN.
  always_comb begin
    fa_a = running & a_sh_q[0];
    fa_b = running & b_sh_q[0];
    fa_c = running & carry_q;
  end

  assign busy = running;
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

  // Next-state: capture on accept, one bit per cycle in RUN, commit on the last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        res_d   = res_shifted;
        carry_d = fa_y[1];
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          sum_d   = res_shifted;
          cout_d  = fa_y[1];
        end
      end
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d = ST_RUN;
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          carry_d = cin;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything, discarding any partial result.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_CHECK_EN
  logic       err_q, err_d;
  logic [1:0] fa_exp;

  assign fa_exp = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_c};

  // Sticky mismatch flag: set by any bad adder result in RUN, cleared by a new operation.
  always_comb begin
    err_d = err_q;
    if (accept) begin
      err_d = 1'b0;
    end else if (running && (fa_y != fa_exp)) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl with an in-bench full adder
module tb_serial_add_ctrl;

  localparam int W = 8;
`ifdef SERIAL_ADD_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         n_reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         cin = 1'b0;
  logic         fa_a, fa_b, fa_c;
  logic [1:0]   fa_y;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  logic         fault = 1'b0;
  logic [1:0]   fa_raw;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum = '0;
  logic         exp_cout = 1'b0;
  logic         exp_err = 1'b0;

  logic [W-1:0] ra [16];
  logic [W-1:0] rb [16];
  logic         rc [16];
  bit           rch [16];
  int           rf [16];
  int           rm [16];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .fa_a    (fa_a),
    .fa_b    (fa_b),
    .fa_c    (fa_c),
    .fa_y    (fa_y),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .err     (err)
  );

  // External full adder; fault flips the sum bit for one chosen cycle.
  assign fa_raw = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_c};
  assign fa_y   = {fa_raw[1], fa_raw[0] ^ fault};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Carry into bit i of a+b+c, from plain arithmetic on the low i bits.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int i);
    longint unsigned m;
    longint unsigned s;
    m = (64'd1 << i) - 64'd1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return s[i];
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_fa_a"}, fa_a, 0);
    check({tag, "_fa_b"}, fa_b, 0);
    check({tag, "_fa_c"}, fa_c, 0);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_err"}, err, exp_err);
  endtask

  // One addition, entered at a negedge with the DUT in IDLE or DONE.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int fault_bit, input int mid_cycle, input bit chain,
                       input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    logic [W:0] full;
    full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    cin   = 1'($urandom);
    exp_err = 1'b0;
    for (int i = 0; i < W; i++) begin
      check("run_busy", busy, 1);
      check("run_done", done, 0);
      check("run_fa_a", fa_a, a[i]);
      check("run_fa_b", fa_b, b[i]);
      check("run_fa_c", fa_c, carry_into(a, b, c, i));
      check("run_sum_hold", sum, exp_sum);
      check("run_cout_hold", cout, exp_cout);
      check("run_err", err, exp_err);
      fault = (i == fault_bit);
      start = (i == mid_cycle);
      @(negedge clk);
      fault = 1'b0;
      start = 1'b0;
      if (CHK && (i == fault_bit)) exp_err = 1'b1;
    end
    exp_sum  = full[W-1:0] ^ ((fault_bit >= 0) ? (W'(1) << fault_bit) : W'(0));
    exp_cout = full[W];
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_sum", sum, exp_sum);
    check("done_cout", cout, exp_cout);
    check("done_err", err, exp_err);
    check("done_fa_c", fa_c, 0);
    if (chain) begin
      start = 1'b1;
      a_in  = na;
      b_in  = nb;
      cin   = nc;
    end else begin
      @(negedge clk);
      idle_outputs("after_done");
    end
  endtask

  initial begin
    // Reset state.
    #1;
    idle_outputs("reset");
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    idle_outputs("idle");

    // Basic add.
    do_op(8'h35, 8'h4A, 1'b0, -1, -1, 1'b0, '0, '0, 1'b0);
    check("basic_sum", sum, 8'h7F);
    check("basic_cout", cout, 0);

    // Reset asserted mid-run discards the operation.
    start = 1'b1;
    a_in  = 8'hFF;
    b_in  = 8'h5A;
    cin   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    n_reset  = 1'b0;
    exp_sum  = '0;
    exp_cout = 1'b0;
    exp_err  = 1'b0;
    #1;
    idle_outputs("midrun_reset");
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
      check("post_reset_sum", sum, 0);
    end

    // Overflow with carry-in; carry is 1 into every bit.
    do_op(8'hFF, 8'h01, 1'b1, -1, -1, 1'b0, '0, '0, 1'b0);
    check("ovf_sum", sum, 8'h01);
    check("ovf_cout", cout, 1);

    // Start during RUN is ignored.
    do_op(8'h10, 8'h20, 1'b0, -1, 2, 1'b0, '0, '0, 1'b0);
    check("ignore_sum", sum, 8'h30);
    repeat (W + 2) begin
      @(negedge clk);
      check("ignore_no_second_done", done, 0);
    end

    // Back-to-back with start held across DONE.
    do_op(8'h0F, 8'hF0, 1'b0, -1, -1, 1'b1, 8'h80, 8'h80, 1'b0);
    check("b2b1_sum", sum, 8'hFF);
    check("b2b1_cout", cout, 0);
    do_op(8'h80, 8'h80, 1'b0, -1, -1, 1'b0, '0, '0, 1'b0);
    check("b2b2_sum", sum, 8'h00);
    check("b2b2_cout", cout, 1);

    // Faulty adder on bit 2; err sticky past done, cleared by the next start.
    do_op(8'h5C, 8'h27, 1'b0, 2, -1, 1'b0, '0, '0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", err, exp_err);
    end
    do_op(8'h01, 8'h02, 1'b0, -1, -1, 1'b0, '0, '0, 1'b0);
    check("err_cleared", err, 0);

    // Randomized operations against the arithmetic model.
    for (int k = 0; k < 16; k++) begin
      ra[k]  = W'($urandom);
      rb[k]  = W'($urandom);
      rc[k]  = 1'($urandom);
      rch[k] = ($urandom_range(0, 1) == 1) && (k < 15);
      rf[k]  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W - 1)) : -1;
      rm[k]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
    end
    for (int k = 0; k < 16; k++) begin
      do_op(ra[k], rb[k], rc[k], rf[k], rm[k], rch[k],
            (k < 15) ? ra[(k + 1) % 16] : W'(0),
            (k < 15) ? rb[(k + 1) % 16] : W'(0),
            (k < 15) ? rc[(k + 1) % 16] : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
